// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for a 16x8 register file and an external ALU.
// Every non-HALT instruction spends four cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
module cpu_control_unit #(
  parameter int PC_W = 8,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     instr_data,
  input  logic [7:0]      alu_result,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      A_sel,
  output logic [3:0]      B_sel,
  output logic [OP_W-1:0] alu_op,
  output logic [3:0]      replaceSel,
  output logic [7:0]      replaceData,
  output logic            writeEnable,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state;
  logic [15:0]     ir;
  logic [7:0]      wdata;
  logic            we_q;
  logic [3:0]      op;
  logic [3:0]      rd;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic [7:0]      imm8;
  logic [PC_W-1:0] imm_pc;
  logic            writes_reg;

  assign op         = ir[15:12];
  assign rd         = ir[11:8];
  assign ra         = ir[7:4];
  assign rb         = ir[3:0];
  assign imm8       = ir[7:0];
  assign imm_pc     = PC_W'(imm8);
  assign writes_reg = (op >= OP_ADD) && (op <= OP_MOV);

  // Decode is taken from the latched IR only, so it is stable from DECODE onward.
  assign alu_op      = OP_W'(op);
  assign replaceSel  = rd;
  assign replaceData = wdata;
  // A write already scheduled for WRITEBACK must be dropped if reset arrives in that same cycle.
  assign writeEnable = we_q & ~rst;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    A_sel = ra;
    B_sel = rb;
    if (op == OP_MOV) begin
      B_sel = ra;
    end else if (op == OP_JZ) begin
      A_sel = rd;
      B_sel = rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      wdata  <= '0;
      we_q   <= 1'b0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= instr_data;
          state <= S_DECODE;
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          wdata <= (op == OP_LDI) ? imm8 : alu_result;
          if (op == OP_HALT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_WRITEBACK;
            we_q  <= writes_reg;
            if (op == OP_JMP || (op == OP_JZ && alu_zero)) pc <= imm_pc;
            else                                            pc <= pc + PC_W'(1);
          end
        end
        S_WRITEBACK: begin
          we_q  <= 1'b0;
          state <= S_FETCH;
        end
        S_HALT: ;
        default: begin
          state  <= S_IDLE;
          we_q   <= 1'b0;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
